seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 42 ++++
 rtl/seg_hex_decode.sv | 12 +
 rtl/seg_scan_driver.sv | 119 +++++++++++
 tb/tb_seg_scan_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Seven-segment shared definitions: segment bit positions and the active-low hex glyph table.
package seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] M_A = 7'(1 << SEG_A);
    localparam logic [6:0] M_B = 7'(1 << SEG_B);
    localparam logic [6:0] M_C = 7'(1 << SEG_C);
    localparam logic [6:0] M_D = 7'(1 << SEG_D);
    localparam logic [6:0] M_E = 7'(1 << SEG_E);
    localparam logic [6:0] M_F = 7'(1 << SEG_F);
    localparam logic [6:0] M_G = 7'(1 << SEG_G);

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entries list the lit segments; inversion makes them active-low.
    localparam logic [6:0] GLYPH [16] = '{
        ~(M_A | M_B | M_C | M_D | M_E | M_F),        // 0
        ~(M_B | M_C),                                // 1
        ~(M_A | M_B | M_D | M_E | M_G),              // 2
        ~(M_A | M_B | M_C | M_D | M_G),              // 3
        ~(M_B | M_C | M_F | M_G),                    // 4
        ~(M_A | M_C | M_D | M_F | M_G),              // 5
        ~(M_A | M_C | M_D | M_E | M_F | M_G),        // 6
        ~(M_A | M_B | M_C),                          // 7
        ~(M_A | M_B | M_C | M_D | M_E | M_F | M_G),  // 8
        ~(M_A | M_B | M_C | M_D | M_F | M_G),        // 9
        ~(M_A | M_B | M_C | M_E | M_F | M_G),        // A
        ~(M_C | M_D | M_E | M_F | M_G),              // b
        ~(M_A | M_D | M_E | M_F),                    // C
        ~(M_B | M_C | M_D | M_E | M_G),              // d
        ~(M_A | M_D | M_E | M_F | M_G),              // E
        ~(M_A | M_E | M_F | M_G)                     // F
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational (zero latency); no flow control.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = GLYPH[nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with frame snapshots, leading-zero blanking and ghost dead time.
// Outputs registered, one cycle behind the scan state; free-running, no backpressure.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_suppress,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PSC_TC   = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]       psc;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] snap_value;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   snap_blank;
    logic                snap_lz;

    logic                tc;
    logic                load;
    logic                zero_run;
    logic [DIGITS-1:0]   lz_dark;
    logic [3:0]          cur_nib;
    logic                cur_dark;
    logic                cur_dp;
    logic [DIGITS-1:0]   cur_an;
    logic [6:0]          cur_seg;

    assign tc   = (psc == PSC_TC);
    assign load = tc && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc        <= '0;
            idx        <= '0;
            snap_value <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
            snap_lz    <= 1'b0;
        end else begin
            psc <= tc ? '0 : psc + 1'b1;
            if (load) begin
                idx        <= '0;
                snap_value <= value;
                snap_dp    <= dp_in;
                snap_blank <= blank_in;
                snap_lz    <= lz_suppress;
            end else if (tc) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Walk down from the top digit; a digit is a leading zero while every digit above it is zero.
    always_comb begin
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (snap_value[4*i +: 4] == 4'h0);
            lz_dark[i] = zero_run & snap_lz;
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_dark = 1'b1;
        cur_dp   = 1'b0;
        cur_an   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = snap_value[4*i +: 4];
                cur_dark  = snap_blank[i] | lz_dark[i];
                cur_dp    = snap_dp[i];
                cur_an[i] = 1'b0;
            end
        end
    end

    seg_hex_decode u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    // A TC cycle always ends with idx moving, so the following cycle is the dead slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= load;
            if (tc || cur_dark) begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end else begin
                an  <= cur_an;
                seg <= cur_seg;
                dp  <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGITS=4, CLK_DIV=4): stimulus queues per-frame expectations,
// a negedge monitor pops them at each frame_tick and checks every slot of that frame.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic        lz_suppress = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int total = 0;
    int bad = 0;

    seg_scan_driver #(.DIGITS(4), .CLK_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] frame;
        logic [27:0] segs;   // {d3,d2,d1,d0}, 7'h7F for dark digits
        logic [3:0]  dpo;    // expected dp output level per digit
        logic [3:0]  dark;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   frame_cnt = 0;
    bit   mon_en = 1'b0;
    bit   have = 1'b0;
    bit   tick_seen = 1'b0;
    int   phase = 0;
    int   cyc = 0;
    int   last_tick = 0;
    int   k;
    int   r;
    logic [3:0] ea;
    logic [6:0] gl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            have      = 1'b0;
            tick_seen = 1'b0;
        end else begin
            if (frame_tick) begin
                if (tick_seen) check("frame_period", 32'(cyc - last_tick), 32'd16);
                tick_seen = 1'b1;
                last_tick = cyc;
                phase     = 0;
                frame_cnt++;
                have      = 1'b0;
                while (q.size() > 0 && q[0].frame < 32'(frame_cnt)) begin
                    check("frame_skipped", q[0].frame, 32'(frame_cnt));
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].frame == 32'(frame_cnt)) begin
                    cur  = q.pop_front();
                    have = 1'b1;
                end
            end else begin
                phase++;
            end
            if (have && phase < 16) begin
                k = phase / 4;
                r = phase % 4;
                if (r == 0) begin
                    check($sformatf("dead_an_d%0d", k), 32'(an), 32'hF);
                end else begin
                    ea = cur.dark[k] ? 4'hF : (4'hF ^ (4'b0001 << k));
                    check($sformatf("an_d%0d", k), 32'(an), 32'(ea));
                    check($sformatf("seg_d%0d", k), 32'(seg), 32'(cur.segs[7*k +: 7]));
                    check($sformatf("dp_d%0d", k), 32'(dp), 32'(cur.dpo[k]));
                end
            end
        end
    end

    task automatic wait_tick(input string why);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL tick_timeout_%s: got no frame_tick in 64 cycles, expected one", why);
        end
    endtask

    // Inputs change mid-frame (phase 6), so the frame in progress must stay on its old snapshot.
    task automatic apply(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                         input logic lz, input logic [27:0] segs, input logic [3:0] dpo,
                         input logic [3:0] dark);
        exp_t e;
        wait_tick("apply");
        repeat (6) @(negedge clk);
        value       = v;
        dp_in       = d;
        blank_in    = b;
        lz_suppress = lz;
        e.frame = 32'(frame_cnt + 1);
        e.segs  = segs;
        e.dpo   = dpo;
        e.dark  = dark;
        q.push_back(e);
    endtask

    task automatic release_and_check(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_first_an"}, 32'(an), 32'hE);
        check({tag, "_first_seg"}, 32'(seg), 32'h40);
        check({tag, "_first_dp"}, 32'(dp), 32'h1);
        check({tag, "_first_tick"}, 32'(frame_tick), 32'h0);
        for (int i = 2; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (frame_tick) n = i;
        end
        check({tag, "_first_tick_edge"}, 32'(n), 32'd16);
    endtask

    initial begin
        gl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        #2 rst_n = 1'b0;
        #1;
        check("rst0_an", 32'(an), 32'hF);
        check("rst0_seg", 32'(seg), 32'h7F);
        check("rst0_dp", 32'(dp), 32'h1);
        check("rst0_tick", 32'(frame_tick), 32'h0);
        repeat (3) @(negedge clk);
        release_and_check("boot");

        mon_en = 1'b1;
        apply(16'h1234, 4'h0, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0);
        apply(16'h0050, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, 4'hC);
        apply(16'h0000, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 4'hE);
        apply(16'h1000, 4'h0, 4'h0, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0);
        apply(16'h0000, 4'b0101, 4'b0100, 1'b0, {7'h40, 7'h7F, 7'h40, 7'h40}, 4'b1110, 4'b0100);
        for (int n = 0; n < 16; n++) begin
            apply(16'(n), 4'h0, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, gl[n]}, 4'hF, 4'h0);
        end
        wait_tick("drain1");
        wait_tick("drain2");
        check("queue_empty", 32'(q.size()), 32'd0);

        // Reset in the middle of a lit slot must blank the outputs without waiting for a clock edge.
        mon_en = 1'b0;
        begin
            bit lit;
            lit = 1'b0;
            for (int i = 0; i < 20 && !lit; i++) begin
                @(negedge clk);
                if (an != 4'hF) lit = 1'b1;
            end
            check("midreset_found_lit", 32'(lit), 32'h1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst1_an", 32'(an), 32'hF);
        check("rst1_seg", 32'(seg), 32'h7F);
        check("rst1_dp", 32'(dp), 32'h1);
        check("rst1_tick", 32'(frame_tick), 32'h0);
        release_and_check("restart");

        mon_en = 1'b1;
        apply(16'h1234, 4'b1000, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0111, 4'h0);
        wait_tick("drain3");
        wait_tick("drain4");
        check("queue_empty_end", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
